// File: rtl/parking_pkg.sv
// ============================================================================
//  Module      : parking_pkg
//  Description : Parking-event log record format and sizing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

   localparam int MAX_HOUR  = 23;
   localparam int LOG_AW    = 3;
   localparam int LOG_DEPTH = 8;

   typedef struct packed {
      logic       dir;
      logic [4:0] hour;
      logic [4:0] day;
      logic [4:0] occ;
   } log_rec_t;

   function automatic log_rec_t pack_rec(input logic dir, input logic [4:0] hour,
                                         input logic [4:0] day, input logic [4:0] occ);
      log_rec_t r;
      r.dir  = dir;
      r.hour = hour;
      r.day  = day;
      r.occ  = occ;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dual_ram8x16.sv
// ============================================================================
//  Module      : dual_ram8x16
//  Description : 8x16 RAM, synchronous write port, combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_ram8x16 (
   input  logic        clk,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic [2:0]  rd_addr,
   output logic [15:0] rd_data
);

   logic [15:0] r_mem [8];

   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/parking_log_ctrl.sv
// ============================================================================
//  Module      : parking_log_ctrl
//  Description : Ring-buffer controller for the external 8x16 parking-event log
//                RAM; optional overwrite-oldest mode under LOG_OVERWRITE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_log_ctrl
   import parking_pkg::*;
#(
   parameter int AW = LOG_AW,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          evt_valid,
   output logic          evt_ready,
   input  logic          evt_dir,
   input  logic [4:0]    evt_hour,
   input  logic [4:0]    evt_day,
   input  logic [4:0]    evt_occ,
   output logic          bad_evt,
   output logic          log_valid,
   input  logic          log_ready,
   output logic [DW-1:0] log_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ram_wr_en,
   output logic [AW-1:0] ram_wr_addr,
   output logic [DW-1:0] ram_wr_data,
   output logic [AW-1:0] ram_rd_addr,
`ifdef LOG_OVERWRITE_EN
   output logic [7:0]    drop_cnt,
`endif
   input  logic [DW-1:0] ram_rd_data
);

   localparam int            DEPTH        = 2**AW;
   localparam logic [AW:0]   C_FULL_COUNT = (AW+1)'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_log_valid;
   logic [DW-1:0] r_log_data;
   logic          r_bad_evt;

   logic          w_hour_ok;
   logic          w_accept;
   logic          w_write;
   logic          w_load;
   logic          w_overwrite;

   assign full      = (r_count == C_FULL_COUNT);
   assign empty     = (r_count == '0);
   assign w_hour_ok = (evt_hour <= 5'(MAX_HOUR));

`ifdef LOG_OVERWRITE_EN
   assign evt_ready   = !clr;
   // A write into a full log that is not paired with a load evicts the oldest entry.
   assign w_overwrite = w_write & full & !w_load;
`else
   assign evt_ready   = !full & !clr;
   assign w_overwrite = 1'b0;
`endif

   assign w_accept  = evt_valid & evt_ready;
   assign w_write   = w_accept & w_hour_ok;
   assign w_load    = !empty & (!r_log_valid | log_ready) & !clr;

   assign ram_wr_en   = w_write;
   assign ram_wr_addr = r_wr_ptr;
   assign ram_wr_data = pack_rec(evt_dir, evt_hour, evt_day, evt_occ);
   assign ram_rd_addr = r_rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_log_valid <= 1'b0;
         r_log_data  <= '0;
         r_bad_evt   <= 1'b0;
      end else if (clr) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_log_valid <= 1'b0;
         r_log_data  <= '0;
         r_bad_evt   <= 1'b0;
      end else begin
         r_bad_evt <= w_accept & !w_hour_ok;
         if (w_write)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_load | w_overwrite)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_write & !w_load & !w_overwrite)
            r_count <= r_count + 1'b1;
         else if (w_load & !w_write)
            r_count <= r_count - 1'b1;
         if (w_load) begin
            r_log_data  <= ram_rd_data;
            r_log_valid <= 1'b1;
         end else if (r_log_valid & log_ready) begin
            r_log_valid <= 1'b0;
         end
      end
   end

`ifdef LOG_OVERWRITE_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_drop_cnt <= '0;
      else if (clr)
         r_drop_cnt <= '0;
      else if (w_overwrite && (r_drop_cnt != 8'hFF))
         r_drop_cnt <= r_drop_cnt + 1'b1;
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign count     = r_count;
   assign log_valid = r_log_valid;
   assign log_data  = r_log_data;
   assign bad_evt   = r_bad_evt;

endmodule

`default_nettype wire

// File: tb/tb_parking_log_ctrl.sv
// ============================================================================
//  Module      : tb_parking_log_ctrl
//  Description : Directed self-checking bench for parking_log_ctrl + dual_ram8x16.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_log_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_dir;
   logic [4:0]  evt_hour;
   logic [4:0]  evt_day;
   logic [4:0]  evt_occ;
   logic        bad_evt;
   logic        log_valid;
   logic        log_ready;
   logic [15:0] log_data;
   logic [3:0]  count;
   logic        full;
   logic        empty;
   logic        ram_wr_en;
   logic [2:0]  ram_wr_addr;
   logic [15:0] ram_wr_data;
   logic [2:0]  ram_rd_addr;
   logic [15:0] ram_rd_data;
`ifdef LOG_OVERWRITE_EN
   logic [7:0]  drop_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int wr_en_seen = 0;

   always #5 clk = ~clk;

   parking_log_ctrl #(.AW(3), .DW(16)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_dir(evt_dir),
      .evt_hour(evt_hour), .evt_day(evt_day), .evt_occ(evt_occ),
      .bad_evt(bad_evt), .log_valid(log_valid), .log_ready(log_ready),
      .log_data(log_data), .count(count), .full(full), .empty(empty),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_rd_addr(ram_rd_addr),
`ifdef LOG_OVERWRITE_EN
      .drop_cnt(drop_cnt),
`endif
      .ram_rd_data(ram_rd_data)
   );

   dual_ram8x16 ram (
      .clk(clk), .wr_en(ram_wr_en), .wr_addr(ram_wr_addr), .wr_data(ram_wr_data),
      .rd_addr(ram_rd_addr), .rd_data(ram_rd_data)
   );

   always @(negedge clk) if (ram_wr_en === 1'b1) wr_en_seen++;

   // Sequence number k -> record {k[0], k%24, k, k}
   function automatic logic [15:0] mkrec(input int k);
      return {1'(k & 1), 5'(k % 24), 5'(k), 5'(k)};
   endfunction

   task automatic set_evt(input int k);
      evt_dir  = 1'(k & 1);
      evt_hour = 5'(k % 24);
      evt_day  = 5'(k);
      evt_occ  = 5'(k);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; evt_valid = 1'b0; log_ready = 1'b0; set_evt(0);
      #12;
      n_cmp++; if (log_valid !== 1'b0) begin n_err++; $display("FAIL reset_log_valid actual=%b required=0", log_valid); end
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count actual=%0d required=0", count); end
      n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags actual empty=%b full=%b required empty=1 full=0", empty, full); end
      n_cmp++; if (log_data !== 16'h0000 || bad_evt !== 1'b0) begin n_err++; $display("FAIL reset_data actual data=%h bad=%b required 0000/0", log_data, bad_evt); end
      n_cmp++; if (evt_ready !== 1'b1) begin n_err++; $display("FAIL reset_evt_ready actual=%b required=1", evt_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      log_ready = 1'b1;
      evt_dir = 1'b1; evt_hour = 5'd8; evt_day = 5'd3; evt_occ = 5'd5; evt_valid = 1'b1;
      #1;
      n_cmp++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 3'd0 || ram_wr_data !== 16'hA065) begin n_err++;
         $display("FAIL single_write actual en=%b addr=%0d data=%h required 1/0/a065", ram_wr_en, ram_wr_addr, ram_wr_data); end
      tick(); evt_valid = 1'b0;
      n_cmp++; if (count !== 4'd1 || log_valid !== 1'b0) begin n_err++; $display("FAIL single_edge1 actual count=%0d lv=%b required 1/0", count, log_valid); end
      tick();
      n_cmp++; if (log_valid !== 1'b1 || log_data !== 16'hA065) begin n_err++; $display("FAIL single_data actual lv=%b data=%h required 1/a065", log_valid, log_data); end
      n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_err++; $display("FAIL single_count actual count=%0d empty=%b required 0/1", count, empty); end
      tick();
      n_cmp++; if (log_valid !== 1'b0) begin n_err++; $display("FAIL single_consumed actual lv=%b required 0", log_valid); end
   endtask

   // One record lands in the output register, eight more fill the RAM.
   task automatic test_full();
      int   acc;
      logic rdy;
      int   exp_q[$];
      int   got;
      acc = 0;
      log_ready = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         set_evt(k); evt_valid = 1'b1;
         #1 rdy = evt_ready;
         if (k == 10) begin
`ifdef LOG_OVERWRITE_EN
            n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL full_ready10 actual=%b required=1", rdy); end
`else
            n_cmp++; if (rdy !== 1'b0 || full !== 1'b1) begin n_err++; $display("FAIL full_ready10 actual rdy=%b full=%b required 0/1", rdy, full); end
`endif
         end
         tick();
         if (rdy === 1'b1) acc++;
      end
      evt_valid = 1'b0;
`ifdef LOG_OVERWRITE_EN
      n_cmp++; if (acc !== 10) begin n_err++; $display("FAIL full_accepted actual=%0d required=10", acc); end
      n_cmp++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL full_drop_cnt actual=%0d required=1", drop_cnt); end
      exp_q = '{1, 3, 4, 5, 6, 7, 8, 9, 10};
`else
      n_cmp++; if (acc !== 9) begin n_err++; $display("FAIL full_accepted actual=%0d required=9", acc); end
      exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
`endif
      n_cmp++; if (count !== 4'd8 || full !== 1'b1) begin n_err++; $display("FAIL full_count actual count=%0d full=%b required 8/1", count, full); end
      #2;
      n_cmp++; if (log_data !== mkrec(1) || log_valid !== 1'b1) begin n_err++; $display("FAIL full_hold actual lv=%b data=%h required 1/%h", log_valid, log_data, mkrec(1)); end
      log_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
         if (log_valid === 1'b1) begin
            n_cmp++; if (log_data !== mkrec(exp_q[0])) begin n_err++; $display("FAIL full_drain[%0d] actual=%h required=%h", got, log_data, mkrec(exp_q[0])); end
            void'(exp_q.pop_front());
            got++;
         end
         tick();
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL full_drain_timeout actual_left=%0d required=0", exp_q.size()); end
      n_cmp++; if (empty !== 1'b1 || log_valid !== 1'b0) begin n_err++; $display("FAIL full_drained actual empty=%b lv=%b required 1/0", empty, log_valid); end
   endtask

   task automatic test_bad_hour();
      int wr_before;
      wr_before = wr_en_seen;
      evt_dir = 1'b0; evt_hour = 5'd24; evt_day = 5'd1; evt_occ = 5'd2; evt_valid = 1'b1;
      #1;
      n_cmp++; if (evt_ready !== 1'b1 || ram_wr_en !== 1'b0) begin n_err++; $display("FAIL bad_handshake actual rdy=%b wr_en=%b required 1/0", evt_ready, ram_wr_en); end
      tick(); evt_valid = 1'b0;
      n_cmp++; if (bad_evt !== 1'b1 || count !== 4'd0) begin n_err++; $display("FAIL bad_pulse actual bad=%b count=%0d required 1/0", bad_evt, count); end
      tick();
      n_cmp++; if (bad_evt !== 1'b0 || log_valid !== 1'b0) begin n_err++; $display("FAIL bad_clear actual bad=%b lv=%b required 0/0", bad_evt, log_valid); end
      n_cmp++; if (wr_en_seen != wr_before) begin n_err++; $display("FAIL bad_wr_en actual=%0d required=%0d", wr_en_seen, wr_before); end
   endtask

   task automatic test_back_to_back();
      int exp_q[$];
      log_ready = 1'b0;
      for (int k = 11; k <= 15; k++) begin
         set_evt(k); evt_valid = 1'b1;
         tick();
      end
      n_cmp++; if (count !== 4'd4 || log_data !== mkrec(11)) begin n_err++; $display("FAIL b2b_prefill actual count=%0d data=%h required 4/%h", count, log_data, mkrec(11)); end
      log_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         n_cmp++; if (log_valid !== 1'b1 || log_data !== mkrec(11 + c)) begin n_err++; $display("FAIL b2b_out[%0d] actual lv=%b data=%h required 1/%h", c, log_valid, log_data, mkrec(11 + c)); end
         set_evt(16 + c); evt_valid = 1'b1;
         tick();
         n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL b2b_count[%0d] actual=%0d required=4", c, count); end
      end
      evt_valid = 1'b0;
      exp_q = '{21, 22, 23, 24, 25};
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         if (log_valid === 1'b1) begin
            n_cmp++; if (log_data !== mkrec(exp_q[0])) begin n_err++; $display("FAIL b2b_drain actual=%h required=%h", log_data, mkrec(exp_q[0])); end
            void'(exp_q.pop_front());
         end
         tick();
      end
      n_cmp++; if (exp_q.size() != 0 || empty !== 1'b1) begin n_err++; $display("FAIL b2b_drain_done actual_left=%0d empty=%b required 0/1", exp_q.size(), empty); end
   endtask

   task automatic test_clr();
      log_ready = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         set_evt(k); evt_valid = 1'b1;
         tick();
      end
      clr = 1'b1; set_evt(3);
      #1;
      n_cmp++; if (evt_ready !== 1'b0 || ram_wr_en !== 1'b0) begin n_err++; $display("FAIL clr_block actual rdy=%b wr_en=%b required 0/0", evt_ready, ram_wr_en); end
      tick(); clr = 1'b0; evt_valid = 1'b0;
      n_cmp++; if (count !== 4'd0 || log_valid !== 1'b0 || log_data !== 16'h0 || empty !== 1'b1) begin n_err++;
         $display("FAIL clr_flush actual count=%0d lv=%b data=%h empty=%b required 0/0/0000/1", count, log_valid, log_data, empty); end
      n_cmp++; if (ram_wr_addr !== 3'd0 || ram_rd_addr !== 3'd0) begin n_err++; $display("FAIL clr_ptrs actual wr=%0d rd=%0d required 0/0", ram_wr_addr, ram_rd_addr); end
   endtask

   task automatic test_async_reset();
      log_ready = 1'b0;
      for (int k = 4; k <= 6; k++) begin
         set_evt(k); evt_valid = 1'b1;
         tick();
      end
      evt_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (log_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || log_data !== 16'h0) begin n_err++;
         $display("FAIL async_reset actual lv=%b count=%0d empty=%b data=%h required 0/0/1/0000", log_valid, count, empty, log_data); end
      #1 rst_n = 1'b1;
      tick();
      n_cmp++; if (log_valid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL async_after actual lv=%b count=%0d required 0/0", log_valid, count); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_full();
      test_bad_hour();
      test_back_to_back();
      test_clr();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
